// File: rtl/hold_pos_pkg.sv
// rtl/hold_pos_pkg.sv - shared types and helpers for the joystick-to-servo position accumulator
// Purpose: channel state encoding, centre/dead-band derivation and the position clamp.
// Ports: none (package).
package hold_pos_pkg;

  typedef enum logic [1:0] {
    ST_CENTER = 2'd0,
    ST_LEFT   = 2'd1,
    ST_RIGHT  = 2'd2
  } state_t;

  function automatic int center_of(int min_pos, int max_pos);
    return (min_pos + max_pos) >>> 1;
  endfunction

  function automatic int lo_of(int min_pos, int max_pos, int dead_band);
    return center_of(min_pos, max_pos) - dead_band;
  endfunction

  function automatic int hi_of(int min_pos, int max_pos, int dead_band);
    return center_of(min_pos, max_pos) + dead_band;
  endfunction

  // Clamp to [min_pos, max_pos]; the caller narrows the result to W bits.
  function automatic int clamp_pos(int v, int min_pos, int max_pos);
    if (v < min_pos) return min_pos;
    if (v > max_pos) return max_pos;
    return v;
  endfunction

endpackage

// File: rtl/hold_pos_multi_if.sv
// rtl/hold_pos_multi_if.sv - sample/preset/position bundle between samplers, accumulator and PWM
// Purpose: groups every non-clock signal of hold_pos_multi.
// Ports (signals): r_pos, mode, en, preset_vld, preset_ch, preset_val driven by master;
//                  o_pos, o_moving driven by slave (the accumulator).
interface hold_pos_multi_if #(
  parameter int NCH = 4,
  parameter int W   = 10
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*W-1:0] r_pos;
  logic [NCH-1:0]   mode;
  logic [NCH-1:0]   en;
  logic             preset_vld;
  logic [CHW-1:0]   preset_ch;
  logic [W-1:0]     preset_val;
  logic [NCH*W-1:0] o_pos;
  logic [NCH-1:0]   o_moving;

  modport master (
    output r_pos, mode, en, preset_vld, preset_ch, preset_val,
    input  o_pos, o_moving
  );

  modport slave (
    input  r_pos, mode, en, preset_vld, preset_ch, preset_val,
    output o_pos, o_moving
  );

endinterface

// File: rtl/hold_pos_ch.sv
// rtl/hold_pos_ch.sv - one joint channel: region FSM, min/max trackers and held position
// Purpose: excursion mode commits the peak deflection of each finished excursion;
//          rate mode integrates the deflection on every shared tick.
// Ports: CLK, SW1 (sync active-low reset), r (raw sample), mode (0 excursion / 1 rate),
//        en (0 = freeze), tick (rate strobe), preset_ld, preset_val,
//        pos (held clamped position), moving (FSM in LEFT or RIGHT).
import hold_pos_pkg::*;

module hold_pos_ch #(
  parameter int W          = 10,
  parameter int MIN_POS    = 228,
  parameter int MAX_POS    = 830,
  parameter int DEAD_BAND  = 30,
  parameter int GAIN_SHIFT = 0
) (
  input  logic         CLK,
  input  logic         SW1,
  input  logic [W-1:0] r,
  input  logic         mode,
  input  logic         en,
  input  logic         tick,
  input  logic         preset_ld,
  input  logic [W-1:0] preset_val,
  output logic [W-1:0] pos,
  output logic         moving
);

  // Two guard bits keep pos +/- deflection exact before clamping.
  localparam int AW = W + 2;
  typedef logic signed [AW-1:0] sw_t;

  localparam int CENTER = center_of(MIN_POS, MAX_POS);
  localparam int LO     = lo_of(MIN_POS, MAX_POS, DEAD_BAND);
  localparam int HI     = hi_of(MIN_POS, MAX_POS, DEAD_BAND);

  localparam sw_t          CENTER_S = sw_t'(CENTER);
  localparam sw_t          LO_S     = sw_t'(LO);
  localparam sw_t          HI_S     = sw_t'(HI);
  localparam logic [W-1:0] CENTER_W = W'(CENTER);

  state_t       state_q, state_d;
  logic [W-1:0] pos_d;
  logic [W-1:0] min_q, min_d, max_q, max_d;
  logic         mode_q;

  sw_t          r_s, pos_s, defl_l, defl_r, rate_step;
  logic         in_left, in_right;
  logic [W-1:0] pos_after_l, pos_after_r, pos_after_rate, preset_clamped;

  assign r_s   = $signed({2'b00, r});
  assign pos_s = $signed({2'b00, pos});

  assign in_left  = (r_s < LO_S);
  assign in_right = (r_s > HI_S);

  // Peak deflections are non-negative; rate step keeps its sign.
  assign defl_l    = (CENTER_S - $signed({2'b00, min_q})) >>> GAIN_SHIFT;
  assign defl_r    = ($signed({2'b00, max_q}) - CENTER_S) >>> GAIN_SHIFT;
  assign rate_step = (r_s - CENTER_S) >>> GAIN_SHIFT;

  assign pos_after_l    = W'(clamp_pos(int'(pos_s - defl_l),    MIN_POS, MAX_POS));
  assign pos_after_r    = W'(clamp_pos(int'(pos_s + defl_r),    MIN_POS, MAX_POS));
  assign pos_after_rate = W'(clamp_pos(int'(pos_s + rate_step), MIN_POS, MAX_POS));
  assign preset_clamped = W'(clamp_pos(int'($signed({2'b00, preset_val})), MIN_POS, MAX_POS));

  assign moving = (state_q == ST_LEFT) || (state_q == ST_RIGHT);

  always_ff @(posedge CLK) begin
    if (!SW1) begin
      state_q <= ST_CENTER;
      pos     <= CENTER_W;
      min_q   <= CENTER_W;
      max_q   <= CENTER_W;
      mode_q  <= mode;
    end else begin
      state_q <= state_d;
      pos     <= pos_d;
      min_q   <= min_d;
      max_q   <= max_d;
      mode_q  <= mode;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos;
    min_d   = min_q;
    max_d   = max_q;

    if (preset_ld) begin
      pos_d   = preset_clamped;
      state_d = ST_CENTER;
      min_d   = CENTER_W;
      max_d   = CENTER_W;
    end else if (!en) begin
      // Frozen: drop any excursion in flight, keep the position.
      state_d = ST_CENTER;
    end else if (mode != mode_q) begin
      // Mode just changed: discard the excursion, no commit.
      state_d = ST_CENTER;
    end else if (mode) begin
      // Rate mode: state only mirrors the region so o_moving stays meaningful.
      if (in_left)       state_d = ST_LEFT;
      else if (in_right) state_d = ST_RIGHT;
      else               state_d = ST_CENTER;
      if (tick && (in_left || in_right)) pos_d = pos_after_rate;
    end else begin
      case (state_q)
        ST_CENTER: begin
          if (in_left) begin
            state_d = ST_LEFT;
            min_d   = r;
          end else if (in_right) begin
            state_d = ST_RIGHT;
            max_d   = r;
          end
        end
        ST_LEFT: begin
          if (in_left) begin
            if (r < min_q) min_d = r;
          end else if (in_right) begin
            // Direct crossing: commit the left peak and open the right excursion.
            pos_d   = pos_after_l;
            state_d = ST_RIGHT;
            max_d   = r;
          end else begin
            pos_d   = pos_after_l;
            state_d = ST_CENTER;
          end
        end
        ST_RIGHT: begin
          if (in_right) begin
            if (r > max_q) max_d = r;
          end else if (in_left) begin
            pos_d   = pos_after_r;
            state_d = ST_LEFT;
            min_d   = r;
          end else begin
            pos_d   = pos_after_r;
            state_d = ST_CENTER;
          end
        end
        default: state_d = ST_CENTER;
      endcase
    end
  end

endmodule

// File: rtl/hold_pos_multi.sv
// rtl/hold_pos_multi.sv - multi-channel joystick-to-servo position accumulator (top)
// Purpose: shared rate-tick counter, preset channel decode and NCH channel instances.
// Ports: CLK (system clock), SW1 (sync active-low reset),
//        bus (hold_pos_multi_if.slave: r_pos, mode, en, preset_* in; o_pos, o_moving out).
import hold_pos_pkg::*;

module hold_pos_multi #(
  parameter int NCH        = 4,
  parameter int W          = 10,
  parameter int MIN_POS    = 228,
  parameter int MAX_POS    = 830,
  parameter int DEAD_BAND  = 30,
  parameter int GAIN_SHIFT = 0,
  parameter int RATE_DIV   = 50000
) (
  input  logic            CLK,
  input  logic            SW1,
  hold_pos_multi_if.slave bus
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  logic [CW-1:0]  tick_cnt;
  logic           tick;
  logic [NCH-1:0] preset_hit;

  // With RATE_DIV=1 the terminal count is 0, so tick is held high.
  assign tick = (tick_cnt == CW'(RATE_DIV - 1));

  always_ff @(posedge CLK) begin
    if (!SW1)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  always_comb begin
    preset_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      preset_hit[k] = bus.preset_vld && (bus.preset_ch == CHW'(k));
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    hold_pos_ch #(
      .W          (W),
      .MIN_POS    (MIN_POS),
      .MAX_POS    (MAX_POS),
      .DEAD_BAND  (DEAD_BAND),
      .GAIN_SHIFT (GAIN_SHIFT)
    ) u_ch (
      .CLK        (CLK),
      .SW1        (SW1),
      .r          (bus.r_pos[k*W +: W]),
      .mode       (bus.mode[k]),
      .en         (bus.en[k]),
      .tick       (tick),
      .preset_ld  (preset_hit[k]),
      .preset_val (bus.preset_val),
      .pos        (bus.o_pos[k*W +: W]),
      .moving     (bus.o_moving[k])
    );
  end

endmodule
